ram_responder: RTL
==================

// Module: ram_responder
// PURPOSE
// RAM-side responder for the cache miss path: services single-word read/write requests from ram_cache's
// miss/refill engine against an internal word array. It models a slow RAM with a configurable number of wait states.
// Handshake: request valid/ready in, one-cycle response pulse out. Sits directly below the cache in the memory hierarchy.
// PARAMETERS
// DATA_WIDTH          16    word width in bits
// RAM_REGISTER_COUNT  1024  number of words; ADDR_W = $clog2(RAM_REGISTER_COUNT)
// WAIT_STATES         2     extra cycles between accept and response; legal range 0..15
// PORTS
// clk         in   1           single clock, all logic on posedge
// reset       in   1           synchronous, active-high
// req_valid   in   1           request present
// req_ready   out  1           responder can accept a request this cycle
// req_write   in   1           1 = write, 0 = read
// req_addr    in   ADDR_W      word address
// req_wdata   in   DATA_WIDTH  write data
// rsp_valid   out  1           one-cycle pulse: request completed
// rsp_rdata   out  DATA_WIDTH  read data (reads) / committed data (writes)
// busy        out  1           request in flight (state != IDLE)
// BEHAVIOUR
// - One clock (clk); reset is synchronous and active-high. All state changes on the posedge of clk.
// - Reset values: state=IDLE, rsp_valid=0, rsp_rdata=0, busy=0, wait counter=0. req_ready=0 while reset is high.
// - Memory array contents are NOT reset.
// - FSM states:
//   - IDLE: req_ready=1. Accept occurs at edge T0 when req_valid&&req_ready. At accept, latch write/addr/wdata and
//     load cnt=WAIT_STATES. Next state is WAIT if WAIT_STATES>0, else ACCESS.
//   - WAIT: req_ready=0. cnt decrements each edge; when cnt==1, next state is ACCESS.
//   - ACCESS: one cycle, req_ready=0. At the ending edge:
//     - write: array[addr]<=wdata and rsp_rdata<=wdata.
//     - read: rsp_rdata<=array[addr].
//     - Also rsp_valid<=1; next state is RESP.
//   - RESP: rsp_valid=1 for exactly this cycle, req_ready=0. Next state is IDLE.
// - Latency: rsp_valid is high in cycle T0+WAIT_STATES+2 (accept edge = T0).
// - Throughput: one request per WAIT_STATES+3 cycles.
// - No response backpressure: the requester must capture rsp_rdata in the rsp_valid cycle.
// - rsp_rdata holds its value until the next ACCESS edge.
// - Request fields are sampled only at accept. Changes on req_* while busy are ignored.
// - req_valid while req_ready=0 is not queued; the requester must hold it until accepted.
// - Out-of-range address (addr >= RAM_REGISTER_COUNT, non-power-of-2 sizes only): read returns 0, write is dropped.
//   rsp_valid still pulses.
// - Reset mid-operation (WAIT/ACCESS before its ending edge): request aborted, pending write NOT committed,
//   no rsp_valid. Reset on the ACCESS ending edge takes priority: no commit.
// - busy = (state != IDLE); req_ready = !reset && state==IDLE.
// - The read port is synchronous (inferable block RAM): exactly one array access per request, in ACCESS.
// TESTING
// 1. Reset: hold reset 3 cycles -> req_ready=0, rsp_valid=0, rsp_rdata=0, busy=0; first cycle after release req_ready=1.
// 2. WAIT_STATES=2: write 0x1234 @5 accepted at T0 -> rsp_valid only at T0+4, rsp_rdata=0x1234.
//    Then read @5 -> rsp_rdata=0x1234 at T1+4.
// 3. Hold req_valid continuously with alternating addr 1/2 reads -> accepts spaced exactly 5 cycles apart,
//    each rsp_valid one cycle wide, no dropped or duplicated response.
// 4. WAIT_STATES=0: read @0 accepted at T0 -> rsp_valid at T0+2; next accept no earlier than T0+3.
// 5. Write 0xBEEF @7 (prior 0x0001), assert reset during WAIT -> no rsp_valid; later read @7 returns 0x0001.
// 6. Boundary addr 1023 (max): write 0xFFFF, read back 0xFFFF. Read @0 is unaffected (no wrap aliasing).

Source files
------------

// File: rtl/ram_responder.sv
// Slow single-port RAM model below the cache miss path: one request at a time,
// WAIT_STATES extra cycles before a single synchronous array access and a one-cycle response pulse.
module ram_responder #(
    parameter int DATA_WIDTH         = 16,
    parameter int RAM_REGISTER_COUNT = 1024,
    parameter int WAIT_STATES        = 2,
    localparam int ADDR_W            = $clog2(RAM_REGISTER_COUNT)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  busy
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

    localparam logic [3:0] WS4 = 4'(WAIT_STATES);

    state_t                state;
    logic [3:0]            cnt;
    logic                  lat_write;
    logic [ADDR_W-1:0]     lat_addr;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic                  in_range;

    logic [DATA_WIDTH-1:0] mem [RAM_REGISTER_COUNT];

    // Only non-power-of-2 depths can see an address past the end of the array.
    assign in_range  = (32'(lat_addr) < RAM_REGISTER_COUNT);
    assign busy      = (state != S_IDLE);
    assign req_ready = !reset && (state == S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        lat_write <= req_write;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        cnt       <= WS4;
                        state     <= (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
                    end
                end
                S_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) state <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (lat_write)     rsp_rdata <= lat_wdata;
                    else if (in_range) rsp_rdata <= mem[lat_addr];
                    else               rsp_rdata <= '0;
                    rsp_valid <= 1'b1;
                    state     <= S_RESP;
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Array kept in its own unreset block so it maps onto block RAM; reset suppresses the commit.
    always_ff @(posedge clk) begin
        if (!reset && state == S_ACCESS && lat_write && in_range)
            mem[lat_addr] <= lat_wdata;
    end

endmodule
